// File: rtl/sseg_rx_x4.sv
// Recovers four BCD digits from a multiplexed common-anode 7-segment bus.
// Define SSEG_RX_HEX_EN to also accept the A-F glyphs as legal digits.
module sseg_rx_x4 #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sseg_an,
   input  logic [6:0] sseg_ca,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [3:0] bcd3,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       seg_err,
   output logic       an_err
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0][10:0] sync_q;
   logic [10:0]      prev_q;
   logic [7:0]       cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0][3:0]  bcd_q, bcd_d;
   logic [3:0]       valid_q, valid_d;
   logic             frame_q, frame_d;
   logic             seg_err_q, seg_err_d;
   logic             an_err_q, an_err_d;

   logic [10:0] s;
   logic [3:0]  s_an, an_low, base_mask, next_mask;
   logic [6:0]  s_ca;
   logic        changed, commit, one_low;
   logic [1:0]  slot;
   logic [4:0]  dec;

   function automatic logic [4:0] decode(input logic [6:0] ca);
      logic [4:0] r;
      case (ca)
         7'b1000000: r = {1'b1, 4'h0};
         7'b1111001: r = {1'b1, 4'h1};
         7'b0100100: r = {1'b1, 4'h2};
         7'b0110000: r = {1'b1, 4'h3};
         7'b0011001: r = {1'b1, 4'h4};
         7'b0010010: r = {1'b1, 4'h5};
         7'b0000010: r = {1'b1, 4'h6};
         7'b1111000: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0010000: r = {1'b1, 4'h9};
`ifdef SSEG_RX_HEX_EN
         7'b0001000: r = {1'b1, 4'hA};
         7'b0000011: r = {1'b1, 4'hB};
         7'b1000110: r = {1'b1, 4'hC};
         7'b0100001: r = {1'b1, 4'hD};
         7'b0000110: r = {1'b1, 4'hE};
         7'b0001110: r = {1'b1, 4'hF};
`endif
         default:    r = 5'b0;
      endcase
      return r;
   endfunction

   assign s      = sync_q[SYNC_STAGES-1];
   assign s_an   = s[10:7];
   assign s_ca   = s[6:0];
   assign an_low = ~s_an;
   assign one_low = (an_low != 4'b0) && ((an_low & (an_low - 4'd1)) == 4'b0);
   assign dec    = decode(s_ca);

   always_comb begin
      slot = 2'd0;
      case (s_an)
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: slot = 2'd0;
      endcase
   end

   // Saturating run-length counter; a commit fires only on the cycle the run reaches STABLE.
   always_comb begin
      changed = (s != prev_q);
      if (changed)
         cnt_d = 8'd1;
      else if (cnt_q == STABLE)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 8'd1;
      commit = (cnt_d == STABLE) && (changed || (cnt_q != STABLE));
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      bcd_d     = bcd_q;
      valid_d   = valid_q;
      frame_d   = 1'b0;
      seg_err_d = 1'b0;
      an_err_d  = 1'b0;
      base_mask = (state_q == IDLE) ? 4'b0 : mask_q;
      next_mask = base_mask | an_low;
      if (commit && (s_an != 4'b1111)) begin
         if (one_low) begin
            if (dec[4]) begin
               bcd_d[slot]   = dec[3:0];
               valid_d[slot] = 1'b1;
            end else begin
               seg_err_d     = 1'b1;
               valid_d[slot] = 1'b0;
            end
            if (next_mask == 4'b1111) begin
               frame_d = 1'b1;
               mask_d  = 4'b0;
               state_d = IDLE;
            end else begin
               mask_d  = next_mask;
               state_d = COLLECT;
            end
         end else begin
            an_err_d = 1'b1;
         end
      end
   end

   // The synchronizer resets to the idle (all-dark) bus so release from reset looks like a blank period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '1;
         prev_q    <= '1;
         cnt_q     <= 8'd0;
         state_q   <= IDLE;
         mask_q    <= 4'b0;
         bcd_q     <= '0;
         valid_q   <= 4'b0;
         frame_q   <= 1'b0;
         seg_err_q <= 1'b0;
         an_err_q  <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], {sseg_an, sseg_ca}};
         prev_q    <= s;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         mask_q    <= mask_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
         frame_q   <= frame_d;
         seg_err_q <= seg_err_d;
         an_err_q  <= an_err_d;
      end
   end

   assign bcd0        = bcd_q[0];
   assign bcd1        = bcd_q[1];
   assign bcd2        = bcd_q[2];
   assign bcd3        = bcd_q[3];
   assign digit_valid = valid_q;
   assign frame_done  = frame_q;
   assign seg_err     = seg_err_q;
   assign an_err      = an_err_q;

endmodule

// File: tb/tb_sseg_rx_x4.sv
// Randomized and directed bench for sseg_rx_x4 against a pin-history reference model.
module tb_sseg_rx_x4;
   localparam int SYNC = 2;
   localparam int STAB = 2;
   localparam logic [10:0] IDLE_BUS = 11'h7FF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sseg_an = 4'hF;
   logic [6:0] sseg_ca = 7'h7F;
   logic [3:0] bcd0, bcd1, bcd2, bcd3, digit_valid;
   logic       frame_done, seg_err, an_err;

   always #5 clk = ~clk;

   sseg_rx_x4 #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) dut (
      .clk(clk), .rst(rst), .sseg_an(sseg_an), .sseg_ca(sseg_ca),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
      .digit_valid(digit_valid), .frame_done(frame_done),
      .seg_err(seg_err), .an_err(an_err)
   );

   int checks = 0, failures = 0;
   int n_frame = 0, n_seg = 0, n_an = 0;
   int n_legal;
   logic [6:0]  pat[16];
   logic [10:0] hist[$];
   logic [3:0]  m_bcd[4];
   logic [3:0]  m_valid, m_mask;
   logic        m_frame, m_seg, m_an;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input logic [6:0] ca);
      for (int i = 0; i < n_legal; i++)
         if (pat[i] == ca) return i;
      return -1;
   endfunction

   task automatic model_commit(input logic [10:0] v);
      logic [3:0] lows;
      int nlow, n, g;
      lows = ~v[10:7];
      nlow = 0;
      n = 0;
      for (int i = 0; i < 4; i++)
         if (lows[i]) begin nlow++; n = i; end
      if (nlow == 0) return;
      if (nlow > 1) begin m_an = 1'b1; return; end
      g = lookup(v[6:0]);
      if (g >= 0) begin
         m_bcd[n]   = 4'(g);
         m_valid[n] = 1'b1;
      end else begin
         m_seg      = 1'b1;
         m_valid[n] = 1'b0;
      end
      m_mask[n] = 1'b1;
      if (m_mask == 4'hF) begin
         m_frame = 1'b1;
         m_mask  = 4'h0;
      end
   endtask

   // A value commits when the run of identical sampled bus words it belongs to has just reached STAB.
   task automatic model_edge();
      int m, run;
      m_frame = 1'b0; m_seg = 1'b0; m_an = 1'b0;
      m = hist.size() - 1 - SYNC;
      run = 1;
      while (run <= STAB && (m - run) >= 0 && hist[m - run] == hist[m]) run++;
      if (run == STAB) model_commit(hist[m]);
   endtask

   task automatic compare_all();
      check("bcd0", int'(bcd0), int'(m_bcd[0]));
      check("bcd1", int'(bcd1), int'(m_bcd[1]));
      check("bcd2", int'(bcd2), int'(m_bcd[2]));
      check("bcd3", int'(bcd3), int'(m_bcd[3]));
      check("digit_valid", int'(digit_valid), int'(m_valid));
      check("frame_done", int'(frame_done), int'(m_frame));
      check("seg_err", int'(seg_err), int'(m_seg));
      check("an_err", int'(an_err), int'(m_an));
      if (frame_done) n_frame++;
      if (seg_err) n_seg++;
      if (an_err) n_an++;
   endtask

   task automatic cyc(input logic [10:0] v);
      {sseg_an, sseg_ca} = v;
      hist.push_back(v);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic hold(input logic [3:0] an, input logic [6:0] ca, input int n);
      for (int i = 0; i < n; i++) cyc({an, ca});
   endtask

   task automatic do_reset();
      {sseg_an, sseg_ca} = IDLE_BUS;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_bcd[i] = 4'h0;
      m_valid = 4'h0; m_mask = 4'h0;
      m_frame = 1'b0; m_seg = 1'b0; m_an = 1'b0;
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(IDLE_BUS);
      compare_all();
      $display("reset applied t=%0t", $time);
   endtask

   initial begin
      int f0, s0, a0, len;
      logic [3:0] an;
      logic [6:0] ca;
      pat[0]  = 7'h40; pat[1]  = 7'h79; pat[2]  = 7'h24; pat[3]  = 7'h30;
      pat[4]  = 7'h19; pat[5]  = 7'h12; pat[6]  = 7'h02; pat[7]  = 7'h78;
      pat[8]  = 7'h00; pat[9]  = 7'h10; pat[10] = 7'h08; pat[11] = 7'h03;
      pat[12] = 7'h46; pat[13] = 7'h21; pat[14] = 7'h06; pat[15] = 7'h0E;
`ifdef SSEG_RX_HEX_EN
      n_legal = 16;
`else
      n_legal = 10;
`endif
      @(negedge clk);
      do_reset();
      check("rst_valid", int'(digit_valid), 0);

      f0 = n_frame;
      for (int d = 0; d < 4; d++) begin
         hold(~(4'b1 << d), pat[d + 1], 4);
         $display("t1 digit slot=%0d glyph=%0d", d, d + 1);
      end
      hold(4'hF, 7'h7F, 6);
      check("t1_bcd0", int'(bcd0), 1);
      check("t1_bcd1", int'(bcd1), 2);
      check("t1_bcd2", int'(bcd2), 3);
      check("t1_bcd3", int'(bcd3), 4);
      check("t1_valid", int'(digit_valid), 15);
      check("t1_frames", n_frame - f0, 1);

      hold(4'b1110, pat[5], 1);
      hold(4'hF, 7'h7F, 4);
      check("t2_glitch_bcd0", int'(bcd0), 1);
      hold(4'b1110, pat[5], 3);
      hold(4'hF, 7'h7F, 3);
      check("t2_bcd0", int'(bcd0), 5);
      $display("t2 glitch rejection done");

      a0 = n_an;
      hold(4'b1100, 7'h00, 4);
      hold(4'hF, 7'h7F, 4);
      check("t3_an_err_count", n_an - a0, 1);
      check("t3_valid", int'(digit_valid), 15);
      $display("t3 multi-anode done");

      s0 = n_seg;
      hold(4'b1011, 7'h08, 4);
      hold(4'hF, 7'h7F, 4);
`ifdef SSEG_RX_HEX_EN
      check("t4_bcd2_hex", int'(bcd2), 10);
      check("t4_valid2", int'(digit_valid[2]), 1);
`else
      check("t4_seg_err_count", n_seg - s0, 1);
      check("t4_valid2", int'(digit_valid[2]), 0);
      check("t4_bcd2_kept", int'(bcd2), 3);
`endif
      $display("t4 hex glyph done");

      hold(4'b1110, pat[8], 4);
      hold(4'b1101, pat[9], 4);
      hold(4'hF, 7'h7F, 4);
      do_reset();
      check("t5_rst_bcd0", int'(bcd0), 0);
      f0 = n_frame;
      hold(4'b1110, pat[9], 4);
      hold(4'b1101, pat[8], 4);
      hold(4'b1011, pat[7], 4);
      hold(4'hF, 7'h7F, 4);
      check("t5_no_early_frame", n_frame - f0, 0);
      hold(4'b0111, pat[6], 4);
      hold(4'hF, 7'h7F, 6);
      check("t5_frames", n_frame - f0, 1);
      $display("t5 reset mid-frame done");

      f0 = n_frame;
      hold(4'b0111, pat[7], 100);
      hold(4'hF, 7'h7F, 4);
      check("t6_bcd3", int'(bcd3), 7);
      check("t6_frames", n_frame - f0, 0);
      $display("t6 long hold done");

      for (int k = 0; k < 400; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6) an = ~(4'b1 << $urandom_range(0, 3));
         else if (r < 8) an = 4'hF;
         else an = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 7) ca = pat[$urandom_range(0, 15)];
         else ca = 7'($urandom_range(0, 127));
         len = $urandom_range(1, 6);
         if ($urandom_range(0, 99) < 2) do_reset();
         hold(an, ca, len);
         $display("rand k=%0d an=%b ca=%b len=%0d", k, an, ca, len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sseg_rx_x4.md
Name: sseg_rx_x4

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver. It samples a common-anode display bus (active-low anodes and cathodes) and recovers the four displayed digits as BCD.
- Also reports per-digit validity, frame completion, and protocol errors.
- Used as a display monitor/loopback checker in the scoreboard path and in system-level self-test.

Parameters:
SYNC_STAGES, 2, number of flops in the input synchronizer on sseg_an/sseg_ca (min 2)
STABLE_CYCLES, 2, consecutive identical synchronized samples required before a digit is committed (min 1, max 255)

Ports:
clk  input  1  posedge clock
rst  input  1  reset; asynchronous, active-high
sseg_an  input  4  anode select, active low; bit N low = digit N shown
sseg_ca  input  7  segments, active low, order {g,f,e,d,c,b,a}
bcd0  output  4  recovered digit 0
bcd1  output  4  recovered digit 1
bcd2  output  4  recovered digit 2
bcd3  output  4  recovered digit 3
digit_valid  output  4  bit N high = bcdN holds a successfully decoded digit
frame_done  output  1  1-cycle pulse when all four digits have been committed since the last pulse or reset
seg_err  output  1  1-cycle pulse when a committed pattern is not a legal glyph
an_err  output  1  1-cycle pulse when a stable anode pattern has more than one low bit

Behaviour:
- Reset (async, rst=1): all outputs 0; synchronizers, stability counter, commit mask and FSM cleared; FSM = IDLE.
- Input path: {sseg_an, sseg_ca} pass through a SYNC_STAGES flop chain. All logic below sees only the synchronized value S.
- Stability:
  - cnt increments while S equals the previous S, saturating at STABLE_CYCLES; cnt reloads to 1 when S changes.
  - A commit fires on the single cycle cnt reaches STABLE_CYCLES.
  - No re-commit occurs until S changes, so a long hold commits once.
- Latency: outputs update on the clock edge SYNC_STAGES+STABLE_CYCLES cycles after the pins change. With defaults this is 4 cycles.
- Commit classification:
  - an == 4'b1111: blank period. No update, no error.
  - an has exactly one low bit N: decode sseg_ca.
    - Legal glyph: bcdN <= value, digit_valid[N] <= 1, mask[N] <= 1.
    - Illegal glyph: seg_err pulses, digit_valid[N] <= 0, bcdN holds its old value, mask[N] <= 1 (the slot was observed).
  - Two or more low bits: an_err pulses; no digit or mask update.
- Glyph table (sseg_ca, active low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - All other patterns, including 1111111 with an anode active, are illegal.
- FSM:
  - IDLE -> COLLECT on the first digit commit.
  - COLLECT stays while mask != 4'b1111.
  - When mask reaches 1111: frame_done pulses on that same edge, mask clears, FSM -> IDLE.
  - A repeated digit within a frame overwrites bcdN and does not advance the mask.
- Simultaneous events: seg_err and frame_done may pulse on the same edge (illegal glyph on the last slot). an_err never coincides with a commit.
- Reset mid-frame: the partial mask is discarded; frame_done requires four fresh slots after release.

Optional Feature:
- Macro: SSEG_RX_HEX_EN.
- Defined: glyphs A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110 are legal and decode to 4'hA–4'hF.
- Undefined: these patterns are illegal and raise seg_err as above.

Test Plan:
- Rotate an 1110, 1101, 1011, 0111 with glyphs 1, 2, 3, 4, holding each 4 cycles -> bcd0..3 = 1, 2, 3, 4; digit_valid = 1111; single frame_done pulse 4 cycles after the 4th digit appears.
- Hold an=1110 with ca=0010010 for 1 cycle, then 1111111 on a blank anode -> no commit; bcd0 unchanged, no pulses. Next, the same glyph held for 3 cycles -> bcd0 = 5 after 4 cycles.
- an=1100, ca=0000000 held 4 cycles -> one an_err pulse; bcd/digit_valid/mask unchanged.
- an=1011, ca=0001000 held -> macro off: seg_err pulse, digit_valid[2] = 0, bcd2 keeps its prior value. Macro on: bcd2 = 4'hA, digit_valid[2] = 1.
- Commit digits 0 and 1, assert rst for 1 cycle, then send a full 4-digit frame -> all outputs 0 after reset; exactly one frame_done, only after the 4th new digit.
- Hold an=0111, ca=1111000 for 100 cycles -> exactly one commit (bcd3 = 7); no frame_done unless other slots follow.
